// File: rtl/itf_arb_pkg.sv
// Shared encodings and helpers for the SPI/I2C command arbiter.
// Imported by itf_cmd_arbiter and itf_flag_mux.
package itf_arb_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LAUNCH = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_GUARD  = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LAUNCH = ST_LAUNCH,
    WAIT   = ST_WAIT,
    DONE   = ST_DONE,
    GUARD  = ST_GUARD
  } arb_state_t;

  localparam logic REQ_HOST = 1'b0;
  localparam logic REQ_POLL = 1'b1;

  localparam logic OP_WR = 1'b1;
  localparam logic OP_RD = 1'b0;

  localparam logic SEL_SPI = 1'b1;
  localparam logic SEL_I2C = 1'b0;

  localparam logic [7:0] TIMEOUT_RDATA = 8'h00;

  // Attributes of the transaction in flight; address/data live in the output bytes.
  typedef struct packed {
    logic wr;
    logic id;
    logic sel;
  } txn_t;

  // A lone request wins outright; a tie goes to the requester not served last.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
    if (req0 && req1) return ~last;
    return req1 ? REQ_POLL : REQ_HOST;
  endfunction

endpackage

// File: rtl/itf_flag_mux.sv
// Picks completion flags and read data of the latched interface, and the
// flag that completes the latched operation type.
module itf_flag_mux
  import itf_arb_pkg::*;
(
  input  logic       sel_lat,
  input  logic       wr_lat,
  input  logic       spi_w_finish,
  input  logic       spi_rd_data_valid_flag,
  input  logic [7:0] spi_rd_data_reg,
  input  logic       i2c_w_finish,
  input  logic       i2c_rd_valid_flag,
  input  logic [7:0] i2c_rd_data_reg,
  output logic       w_finish,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       done_evt,
  output logic       flags_busy
);

  always_comb begin
    w_finish = i2c_w_finish;
    rd_valid = i2c_rd_valid_flag;
    rd_data  = i2c_rd_data_reg;
    if (sel_lat == SEL_SPI) begin
      w_finish = spi_w_finish;
      rd_valid = spi_rd_data_valid_flag;
      rd_data  = spi_rd_data_reg;
    end
  end

  assign done_evt   = (wr_lat == OP_WR) ? w_finish : rd_valid;
  // Masters hold their flags as levels; either one still high blocks re-arbitration.
  assign flags_busy = w_finish | rd_valid;

endmodule

// File: rtl/itf_cmd_arbiter.sv
// Round-robin arbiter sharing the SPI/I2C byte masters between the host FIFO
// command path (requester 0) and the status poller (requester 1).
//
// state  | meaning
// IDLE   | no transaction; arbitrate pending requests
// LAUNCH | one-cycle start strobe to both masters
// WAIT   | wait for the latched completion flag or timeout
// DONE   | one-cycle ack pulse with result
// GUARD  | wait for the latched interface flags to drop
module itf_cmd_arbiter
  import itf_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       itf_sel,
  input  logic       r0_req,
  input  logic       r1_req,
  input  logic       r0_wr,
  input  logic       r1_wr,
  input  logic [7:0] r0_addr,
  input  logic [7:0] r1_addr,
  input  logic [7:0] r0_wdata,
  input  logic [7:0] r1_wdata,
  output logic       r0_ack,
  output logic       r1_ack,
  output logic [7:0] rsp_rdata,
  output logic       rsp_timeout,
  output logic       busy,
  output logic       grant_id,
  output logic [7:0] addr_byte,
  output logic [7:0] data_byte,
  output logic       WriteByteStart,
  output logic       ReadByteStart,
  input  logic       spi_w_finish,
  input  logic       spi_rd_data_valid_flag,
  input  logic       i2c_w_finish,
  input  logic       i2c_rd_valid_flag,
  input  logic [7:0] spi_rd_data_reg,
  input  logic [7:0] i2c_rd_data_reg
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t       state, state_nxt;
  txn_t             txn, txn_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             last_grant, last_grant_nxt;
  logic             r0_ack_nxt, r1_ack_nxt;
  logic             wr_start_nxt, rd_start_nxt;
  logic [7:0]       rsp_rdata_nxt;
  logic             rsp_timeout_nxt;
  logic             busy_nxt;
  logic             grant_id_nxt;
  logic [7:0]       addr_nxt, data_nxt;

  logic             pick_id;
  logic             pick_wr;
  logic             sel_w_finish, sel_rd_valid, done_evt, flags_busy;
  logic [7:0]       sel_rd_data;

  assign pick_id = rr_pick(r0_req, r1_req, last_grant);
  assign pick_wr = pick_id ? r1_wr : r0_wr;

  itf_flag_mux u_flag_mux (
    .sel_lat                (txn.sel),
    .wr_lat                 (txn.wr),
    .spi_w_finish           (spi_w_finish),
    .spi_rd_data_valid_flag (spi_rd_data_valid_flag),
    .spi_rd_data_reg        (spi_rd_data_reg),
    .i2c_w_finish           (i2c_w_finish),
    .i2c_rd_valid_flag      (i2c_rd_valid_flag),
    .i2c_rd_data_reg        (i2c_rd_data_reg),
    .w_finish               (sel_w_finish),
    .rd_valid               (sel_rd_valid),
    .rd_data                (sel_rd_data),
    .done_evt               (done_evt),
    .flags_busy             (flags_busy)
  );

  always_comb begin
    state_nxt       = state;
    txn_nxt         = txn;
    cnt_nxt         = cnt;
    last_grant_nxt  = last_grant;
    r0_ack_nxt      = 1'b0;
    r1_ack_nxt      = 1'b0;
    wr_start_nxt    = 1'b0;
    rd_start_nxt    = 1'b0;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_timeout_nxt = rsp_timeout;
    grant_id_nxt    = grant_id;
    addr_nxt        = addr_byte;
    data_nxt        = data_byte;

    case (state)
      IDLE: begin
        if (r0_req || r1_req) begin
          txn_nxt.wr   = pick_wr;
          txn_nxt.id   = pick_id;
          txn_nxt.sel  = itf_sel;
          grant_id_nxt = pick_id;
          addr_nxt     = pick_id ? r1_addr : r0_addr;
          data_nxt     = pick_id ? r1_wdata : r0_wdata;
          wr_start_nxt = (pick_wr == OP_WR);
          rd_start_nxt = (pick_wr == OP_RD);
          state_nxt    = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_nxt   = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        // A completion in the terminal cycle still counts as success.
        if (done_evt) begin
          rsp_rdata_nxt   = (txn.wr == OP_WR) ? TIMEOUT_RDATA : sel_rd_data;
          rsp_timeout_nxt = 1'b0;
          r0_ack_nxt      = (txn.id == REQ_HOST);
          r1_ack_nxt      = (txn.id == REQ_POLL);
          state_nxt       = DONE;
        end else if (cnt == CNT_LAST) begin
          rsp_rdata_nxt   = TIMEOUT_RDATA;
          rsp_timeout_nxt = 1'b1;
          r0_ack_nxt      = (txn.id == REQ_HOST);
          r1_ack_nxt      = (txn.id == REQ_POLL);
          state_nxt       = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        last_grant_nxt = txn.id;
        state_nxt      = GUARD;
      end
      GUARD: begin
        if (!flags_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      txn            <= '0;
      cnt            <= '0;
      last_grant     <= REQ_POLL;
      r0_ack         <= 1'b0;
      r1_ack         <= 1'b0;
      WriteByteStart <= 1'b0;
      ReadByteStart  <= 1'b0;
      rsp_rdata      <= 8'h00;
      rsp_timeout    <= 1'b0;
      busy           <= 1'b0;
      grant_id       <= 1'b0;
      addr_byte      <= 8'h00;
      data_byte      <= 8'h00;
    end else begin
      state          <= state_nxt;
      txn            <= txn_nxt;
      cnt            <= cnt_nxt;
      last_grant     <= last_grant_nxt;
      r0_ack         <= r0_ack_nxt;
      r1_ack         <= r1_ack_nxt;
      WriteByteStart <= wr_start_nxt;
      ReadByteStart  <= rd_start_nxt;
      rsp_rdata      <= rsp_rdata_nxt;
      rsp_timeout    <= rsp_timeout_nxt;
      busy           <= busy_nxt;
      grant_id       <= grant_id_nxt;
      addr_byte      <= addr_nxt;
      data_byte      <= data_nxt;
    end
  end

endmodule
